// File: rtl/vec_decode_stage_if.sv
// Fetch-to-execute handshake bundle for the vector decode stage.
// The slave modport is the decode stage's view of the bundle. The master
// modport is the surrounding environment's view: fetch drives the inputs
// and execute drives out_ready.
interface vec_decode_stage_if #(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 4,
    parameter int NUM_OPS = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic [INSTR_W-1:0]      in_instr;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_OPS-1:0]      out_op;
    logic                    out_illegal;
    logic [INSTR_W-OP_W-1:0] out_operand;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_op, out_illegal, out_operand
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_op, out_illegal, out_operand
    );
endinterface

// File: rtl/vec_decode_stage.sv
// Registered instruction-decode stage: opcode -> one-hot op vector, illegal
// flag, and an issue lockout after multi-cycle ops are accepted.
module vec_decode_stage #(
    parameter int                 INSTR_W    = 16,
    parameter int                 OP_W       = 4,
    parameter int                 NUM_OPS    = 10,
    parameter logic [NUM_OPS-1:0] MULTI_MASK = 10'b0100000000,
    parameter int                 MC_CYCLES  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vec_decode_stage_if.slave    dec_if,
    output logic                 busy_o,
    output logic [7:0]           illegal_cnt_o
);
    localparam int OPD_W = INSTR_W - OP_W;
    // Keep the counter at least one bit wide so MC_CYCLES = 0 still elaborates.
    localparam int CNT_W = (MC_CYCLES > 0) ? $clog2(MC_CYCLES + 1) : 1;
    localparam logic [OP_W-1:0]  NOP_OPC  = '1;
    localparam logic [CNT_W-1:0] MC_LOAD  = CNT_W'(MC_CYCLES);

    logic [OP_W-1:0]    opcode;
    logic [NUM_OPS-1:0] dec_op;
    logic               dec_illegal;
    logic               dec_multi;
    logic               in_ready;
    logic               accept;

    logic               out_valid_q, out_valid_d;
    logic [NUM_OPS-1:0] out_op_q, out_op_d;
    logic               out_illegal_q, out_illegal_d;
    logic [OPD_W-1:0]   out_operand_q, out_operand_d;
    logic [CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [7:0]         illegal_cnt_q, illegal_cnt_d;

    assign opcode = dec_if.in_instr[INSTR_W-1 -: OP_W];

    // Opcodes 0..NUM_OPS-2 map straight onto their bit index; the all-ones
    // opcode is NOP on the top bit. Everything in between decodes to zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS - 1; gi++) begin : g_dec
            assign dec_op[gi] = (opcode == OP_W'(gi));
        end
    endgenerate
    assign dec_op[NUM_OPS-1] = (opcode == NOP_OPC);

    assign dec_illegal = ~|dec_op;
    assign dec_multi   = |(dec_op & MULTI_MASK);

    // Ready never looks at in_valid, so fetch can safely wait on it.
    assign in_ready = (!out_valid_q || dec_if.out_ready) && (mc_cnt_q == '0);
    assign accept   = dec_if.in_valid && in_ready;

    // Next-state for the output register, lockout counter and trap counter.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_illegal_d = out_illegal_q;
        out_operand_d = out_operand_q;
        mc_cnt_d      = mc_cnt_q;
        illegal_cnt_d = illegal_cnt_q;

        if (accept) begin
            // A new accept also covers a same-cycle drain, so there is no bubble.
            out_valid_d   = 1'b1;
            out_op_d      = dec_op;
            out_illegal_d = dec_illegal;
            out_operand_d = dec_if.in_instr[OPD_W-1:0];
        end else if (out_valid_q && dec_if.out_ready) begin
            out_valid_d = 1'b0;
        end

        // dec_multi already implies a legal opcode, so traps never lock out.
        if (accept && dec_multi) begin
            mc_cnt_d = MC_LOAD;
        end else if (mc_cnt_q != '0) begin
            mc_cnt_d = mc_cnt_q - 1'b1;
        end

        if (accept && dec_illegal && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    // State registers; reset drops any held result and the lockout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_illegal_q <= 1'b0;
            out_operand_q <= '0;
            mc_cnt_q      <= '0;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_illegal_q <= out_illegal_d;
            out_operand_q <= out_operand_d;
            mc_cnt_q      <= mc_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign dec_if.in_ready    = in_ready;
    assign dec_if.out_valid   = out_valid_q;
    assign dec_if.out_op      = out_op_q;
    assign dec_if.out_illegal = out_illegal_q;
    assign dec_if.out_operand = out_operand_q;
    assign busy_o             = (mc_cnt_q != '0);
    assign illegal_cnt_o      = illegal_cnt_q;
endmodule

// File: tb/tb_vec_decode_stage.sv
// Bench for vec_decode_stage: directed steps plus random traffic, all checked
// against a cycle-indexed reference model of the decode and lockout rules.
module tb_vec_decode_stage;
    localparam int MC      = 3;
    localparam int NOPS    = 10;
    localparam int OPW     = 4;
    localparam int NOPS2   = 16;
    localparam int OPW2    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy1, busy2;
    logic [7:0] icnt1, icnt2;

    always #5 clk = ~clk;

    vec_decode_stage_if #(.INSTR_W(16), .OP_W(OPW),  .NUM_OPS(NOPS))  b1 ();
    vec_decode_stage_if #(.INSTR_W(16), .OP_W(OPW2), .NUM_OPS(NOPS2)) b2 ();

    vec_decode_stage #(
        .INSTR_W(16), .OP_W(OPW), .NUM_OPS(NOPS),
        .MULTI_MASK(10'b0100000000), .MC_CYCLES(MC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dec_if(b1.slave),
        .busy_o(busy1), .illegal_cnt_o(icnt1)
    );

    vec_decode_stage #(
        .INSTR_W(16), .OP_W(OPW2), .NUM_OPS(NOPS2),
        .MULTI_MASK(16'h0008), .MC_CYCLES(0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .dec_if(b2.slave),
        .busy_o(busy2), .illegal_cnt_o(icnt2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state. cyc counts rising edges since time zero; a
    // multi-cycle op accepted at edge N allows the next accept at edge
    // N+MC+1, i.e. ready again once cyc >= N+MC.
    int         cyc = 0;
    int         unlock = 0;
    logic       m_valid = 1'b0;
    logic [9:0] m_op = '0;
    logic       m_ill = 1'b0;
    logic [11:0] m_opnd = '0;
    int         m_icnt = 0;
    logic [9:0] mask1 = 10'b0100000000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ref_decode(input int opc);
        if (opc == (1 << OPW) - 1) return 10'(1 << (NOPS - 1));
        if (opc <= NOPS - 2)       return 10'(1 << opc);
        return 10'd0;
    endfunction

    function automatic logic [15:0] ref_decode2(input int opc);
        if (opc == (1 << OPW2) - 1) return 16'(1 << (NOPS2 - 1));
        if (opc <= NOPS2 - 2)       return 16'(1 << opc);
        return 16'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // One clock of traffic on the default instance, checked before and after the edge.
    task automatic step(input logic v, input logic [15:0] ins, input logic ordy, output logic acc);
        logic exp_ready;
        int   opc;
        b1.in_valid  = v;
        b1.in_instr  = ins;
        b1.out_ready = ordy;
        #1;
        exp_ready = (!m_valid || ordy) && (cyc >= unlock);
        chk("in_ready", b1.in_ready, exp_ready);
        chk("busy_pre", busy1, cyc < unlock);
        acc = v && exp_ready;
        opc = int'(ins[15:12]);
        @(posedge clk);
        cyc++;
        if (acc) begin
            m_valid = 1'b1;
            m_op    = ref_decode(opc);
            m_ill   = (m_op == 0);
            m_opnd  = ins[11:0];
            if ((m_op & mask1) != 0) unlock = cyc + MC;
            if (m_ill && m_icnt < 255) m_icnt++;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", b1.out_valid, m_valid);
        chk("out_op", b1.out_op, m_op);
        chk("out_illegal", b1.out_illegal, m_ill);
        chk("out_operand", b1.out_operand, m_opnd);
        chk("illegal_cnt", icnt1, m_icnt);
        chk("busy_post", busy1, cyc < unlock);
        $display("cyc=%0d v=%0b instr=%h ordy=%0b acc=%0b out_valid=%0b out_op=%h ill=%0b busy=%0b icnt=%0d",
                 cyc, v, ins, ordy, acc, b1.out_valid, b1.out_op, b1.out_illegal, busy1, icnt1);
    endtask

    // Hold in_valid until the instruction is taken; returns cycles spent.
    task automatic send(input logic [15:0] ins, output int tries);
        logic acc;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            step(1'b1, ins, 1'b1, acc);
            tries++;
        end
        chk("send_timeout", acc, 1'b1);
    endtask

    // One accept on the wide-opcode instance with lockout disabled.
    task automatic step2(input logic [15:0] ins);
        b2.in_valid  = 1'b1;
        b2.in_instr  = ins;
        b2.out_ready = 1'b1;
        #1;
        chk("p2_in_ready", b2.in_ready, 1'b1);
        tick();
        chk("p2_out_op", b2.out_op, ref_decode2(int'(ins[15:11])));
        chk("p2_illegal", b2.out_illegal, ref_decode2(int'(ins[15:11])) == 0);
        chk("p2_operand", b2.out_operand, ins[10:0]);
        chk("p2_busy", busy2, 1'b0);
        $display("p2 instr=%h out_op=%h ill=%0b busy=%0b", ins, b2.out_op, b2.out_illegal, busy2);
        b2.in_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        int   tries;
        b1.in_valid = 1'b0; b1.in_instr = '0; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.in_instr = '0; b2.out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", b1.out_valid, 1'b0);
        chk("rst_out_op", b1.out_op, 0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_icnt", icnt1, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", b1.in_ready, 1'b1);

        // Stream every legal opcode; opcode 8 carries the multi-cycle mask bit.
        for (int k = 0; k <= 8; k++) send({4'(k), 12'(k * 16'h111)}, tries);
        send(16'hF5A5, tries);
        step(1'b0, 16'h0000, 1'b1, acc);

        // Illegal opcodes, then drive the trap counter into saturation.
        for (int k = 9; k <= 14; k++) send({4'(k), 12'h123}, tries);
        chk("icnt_six", icnt1, 6);
        for (int k = 0; k < 300; k++) send({4'($urandom_range(9, 14)), 12'($urandom)}, tries);
        chk("icnt_sat", icnt1, 255);

        // Lockout: the follow-up instruction must wait exactly MC cycles.
        send(16'h8001, tries);
        chk("lock_busy", busy1, 1'b1);
        send(16'h3002, tries);
        chk("lock_tries", tries, MC + 1);
        chk("lock_busy_after", busy1, 1'b0);

        // Back-pressure hold then drain-with-accept on the same edge.
        send(16'h2ABC, tries);
        for (int k = 0; k < 5; k++) step(1'b1, 16'h5555, 1'b0, acc);
        chk("bp_op", b1.out_op, 10'h004);
        chk("bp_operand", b1.out_operand, 12'hABC);
        step(1'b1, 16'h4321, 1'b1, acc);
        chk("bp_accept", acc, 1'b1);

        // Asynchronous reset in the middle of a lockout with a held result.
        send(16'h8777, tries);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", b1.out_valid, 1'b0);
        chk("arst_op", b1.out_op, 0);
        chk("arst_ill", b1.out_illegal, 1'b0);
        chk("arst_operand", b1.out_operand, 0);
        chk("arst_busy", busy1, 1'b0);
        chk("arst_icnt", icnt1, 0);
        m_valid = 1'b0; m_op = '0; m_ill = 1'b0; m_opnd = '0; m_icnt = 0; unlock = 0;
        tick();
        rst_n = 1'b1;
        send(16'h6DEF, tries);
        chk("arst_first_tries", tries, 1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0), acc);
        end
        step(1'b0, 16'h0, 1'b1, acc);

        // Wide-opcode instance: all-ones is NOP, 0x0F..0x1E trap, no lockout.
        step2({5'h1F, 11'h7FF});
        step2({5'h0F, 11'h001});
        step2({5'h10, 11'h002});
        step2({5'h0E, 11'h003});
        step2({5'h03, 11'h004});
        step2({5'h00, 11'h005});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
